spdot_spad_loader: RTL and testbench
====================================

# spdot_spad_loader

Upstream feeder for the `spdot_bsr_core` compute loop. It accepts a single valid/ready word stream from the memory side and fills two scratchpad banks, Q first and then K. Once both banks are loaded it launches the core with a one-cycle start pulse and holds until the core reports done. The Q and K scratchpads live in this block, which also serves the core's read ports.

## Interface
- `DEPTH`, default 1024: words per bank.
- `AW`, default `$clog2(DEPTH)`: bank address width.
- `DW`, default 32: data word width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `load_start`  in  1  begin a load; sampled only in IDLE.
- `q_words`  in  16  Q word count; latched on an accepted `load_start`.
- `k_words`  in  16  K word count; latched on an accepted `load_start`.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  DW  input word.
- `in_last`  in  1  marks the final K beat.
- `q_raddr`  in  16  core Q read address.
- `q_rdata`  out  DW  Q read data.
- `k_raddr`  in  16  core K read address.
- `k_rdata`  out  DW  K read data.
- `core_start`  out  1  one-cycle launch pulse to the core.
- `core_done`  in  1  core completion; honoured only in WAIT.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky error flag.

## Operation
- FSM states: IDLE, LOAD_Q, LOAD_K, LAUNCH, WAIT.
- IDLE:
  - `load_start` clears `err` and latches both counts.
  - If either count is 0 or either count exceeds `DEPTH`: set `err` and stay in IDLE.
  - Otherwise: clear the write pointer and go to LOAD_Q.
- LOAD_Q:
  - `in_ready` is 1; each accepted beat writes `q_bank[wptr]` and increments `wptr`.
  - On the beat where `wptr == q_words-1`, go to LOAD_K and reset `wptr` to 0.
- LOAD_K: same as LOAD_Q, writing `k_bank`. On the beat where `wptr == k_words-1`, go to LAUNCH.
- Framing check on `in_last`:
  - `in_last` must be 1 on the final K beat and 0 on every other beat.
  - Any mismatch sets `err` and aborts to IDLE; the offending beat is still consumed.
  - If the final K beat arrives without `in_last`, the block sets `err`, aborts and does not launch.
- LAUNCH: `core_start` is 1 for exactly this one cycle, then go to WAIT.
- WAIT: on `core_done`, go to IDLE.
- Ignored inputs:
  - `load_start` outside IDLE is ignored, including when it coincides with `core_done` in WAIT.
  - `core_done` outside WAIT is ignored.
  - `in_valid` outside the LOAD states is ignored (`in_ready` is 0).
- Read ports:
  - Combinational: `q_rdata = q_bank[q_raddr]` when `q_raddr < DEPTH`, else 0. `k_rdata` follows the same rule.
  - Reads are legal in any state.
  - Bank contents persist across loads and are not cleared by reset.

## Timing
- Reset values: state IDLE, `wptr` 0, both latched counts 0. `in_ready`, `core_start`, `busy` and `err` are all 0.
- Reset mid-operation: the FSM returns to IDLE at once and outputs drop asynchronously. Partially written bank contents are retained but undefined for use.
- `in_ready`, `core_start` and `busy` are pure decodes of the registered state, with no combinational path from any input.
- Load start to first accept: `load_start` at edge t means the first beat can be accepted at edge t+1.
- Write to read: a write at edge t is visible on `rdata` after edge t.
- Launch latency: final K beat accepted at edge n gives `core_start` high during cycle n..n+1; WAIT begins from edge n+1.
- Minimum load time: `q_words + k_words` cycles with `in_valid` held at 1. Bubbles on `in_valid` stall progress without duplicating or dropping beats.
- Width rules:
  - Counts are compared as 16-bit unsigned values against `DEPTH`.
  - `wptr` is AW+1 bits wide, so it cannot wrap when `count == DEPTH`.

## Structure
- Shared package `spdot_pkg` holds:
  - the `loader_state_e` enum;
  - `SPDOT_DW` and `SPDOT_DEPTH` defaults;
  - the count width of 16.
- Sub-module `spdot_spad_bank`: one write port and one combinational read port, with an out-of-range read returning 0. It is instantiated twice, for Q and K.

## Test plan
- Basic load and launch: `q_words=4`, `k_words=4`, stream 0x10..0x13 then 0x20..0x23, `in_last` on beat 8.
  - `core_start` pulses once, in the cycle after beat 8.
  - `q_rdata@2` reads 0x12 and `k_rdata@3` reads 0x23.
- Bubbles: same stream with `in_valid` toggling 1,0,0,1. Bank contents match the basic case and `core_start` appears only after beat 8.
- Early `in_last`: `in_last` on Q beat 3 gives `err=1` and IDLE next cycle, with `in_ready=0` and no `core_start`.
- Bad counts: `q_words=0` gives `err=1`, and so does `k_words=1025`. In both cases `busy` and `in_ready` stay 0.
- Reset mid-load: assert `rst` in LOAD_K.
  - `busy` and `in_ready` drop immediately.
  - A following 2+2 load launches normally.
- Launch handshake: `load_start` pulsed in WAIT is ignored. `busy` stays 1 until `core_done` and falls on the next edge.

Source files
------------

// File: rtl/spdot_pkg.sv
// spdot_pkg
//   Shared types and defaults for the spdot scratchpad loader slice.
//   - loader_state_e : loader FSM states
//   - SPDOT_DW       : default data word width
//   - SPDOT_DEPTH    : default words per scratchpad bank
//   - SPDOT_CNT_W    : width of word counts and core read addresses
`timescale 1ns/1ps
package spdot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_Q = 3'd1,
    ST_LOAD_K = 3'd2,
    ST_LAUNCH = 3'd3,
    ST_WAIT   = 3'd4
  } loader_state_e;

  localparam int SPDOT_DW    = 32;
  localparam int SPDOT_DEPTH = 1024;
  localparam int SPDOT_CNT_W = 16;

endpackage

// File: rtl/spdot_spad_loader_if.sv
// spdot_spad_loader_if
//   Bundles every non-clock/reset signal of the loader.
//   master : the memory/core side (drives load control, stream beats,
//            read addresses and core_done)
//   slave  : the loader itself
`timescale 1ns/1ps
interface spdot_spad_loader_if
  import spdot_pkg::*;
#(
  parameter int DW = SPDOT_DW
);
  logic                   load_start;
  logic [SPDOT_CNT_W-1:0] q_words;
  logic [SPDOT_CNT_W-1:0] k_words;
  logic                   in_valid;
  logic                   in_ready;
  logic [DW-1:0]          in_data;
  logic                   in_last;
  logic [SPDOT_CNT_W-1:0] q_raddr;
  logic [DW-1:0]          q_rdata;
  logic [SPDOT_CNT_W-1:0] k_raddr;
  logic [DW-1:0]          k_rdata;
  logic                   core_start;
  logic                   core_done;
  logic                   busy;
  logic                   err;

  modport master (
    output load_start, q_words, k_words, in_valid, in_data, in_last,
           q_raddr, k_raddr, core_done,
    input  in_ready, q_rdata, k_rdata, core_start, busy, err
  );

  modport slave (
    input  load_start, q_words, k_words, in_valid, in_data, in_last,
           q_raddr, k_raddr, core_done,
    output in_ready, q_rdata, k_rdata, core_start, busy, err
  );
endinterface

// File: rtl/spdot_spad_bank.sv
// spdot_spad_bank
//   One scratchpad bank: synchronous write port, combinational read port.
//   Contents are not reset. Reads at or beyond DEPTH return 0.
//   clk   : write clock
//   we    : write enable
//   waddr : write address (always < DEPTH when we is high)
//   wdata : write data
//   raddr : 16-bit read address from the core
//   rdata : read data
`timescale 1ns/1ps
module spdot_spad_bank
  import spdot_pkg::*;
#(
  parameter int DEPTH = SPDOT_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = SPDOT_DW
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [DW-1:0]          wdata,
  input  logic [SPDOT_CNT_W-1:0] raddr,
  output logic [DW-1:0]          rdata
);

  localparam logic [SPDOT_CNT_W:0] DEPTH_W = (SPDOT_CNT_W+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic          in_range;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Range check is done at full read-address width so high addresses
  // never alias onto low entries.
  assign in_range = ({1'b0, raddr} < DEPTH_W);
  assign rdata    = in_range ? mem[raddr[AW-1:0]] : '0;

endmodule

// File: rtl/spdot_spad_loader.sv
// spdot_spad_loader
//   Streams Q then K words into two local scratchpads, launches the
//   spdot core with a one-cycle start pulse and waits for core_done.
//   Also serves the core's combinational Q/K read ports.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : load control, input stream, read ports, core handshake,
//         busy and sticky err (slave modport)
`timescale 1ns/1ps
module spdot_spad_loader
  import spdot_pkg::*;
#(
  parameter int DEPTH = SPDOT_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = SPDOT_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  spdot_spad_loader_if.slave   bus
);

  localparam logic [SPDOT_CNT_W:0] DEPTH_W = (SPDOT_CNT_W+1)'(DEPTH);
  localparam logic [AW:0]          PTR_ONE = {{AW{1'b0}}, 1'b1};

  loader_state_e          state_q, state_d;
  logic [AW:0]            wptr_q, wptr_d;
  logic [SPDOT_CNT_W-1:0] q_cnt_q, q_cnt_d;
  logic [SPDOT_CNT_W-1:0] k_cnt_q, k_cnt_d;
  logic                   err_q, err_d;
  logic                   q_we, k_we;
  logic                   bad_counts;
  logic                   q_final, k_final;
  logic [SPDOT_CNT_W:0]   wptr_ext;

  // Counts are judged on the raw inputs in the same cycle they are latched.
  assign bad_counts = (bus.q_words == '0) || (bus.k_words == '0) ||
                      ({1'b0, bus.q_words} > DEPTH_W) ||
                      ({1'b0, bus.k_words} > DEPTH_W);

  assign wptr_ext = (SPDOT_CNT_W+1)'(wptr_q);
  assign q_final  = (wptr_ext == ({1'b0, q_cnt_q} - 1'b1));
  assign k_final  = (wptr_ext == ({1'b0, k_cnt_q} - 1'b1));

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    q_cnt_d = q_cnt_q;
    k_cnt_d = k_cnt_q;
    err_d   = err_q;
    q_we    = 1'b0;
    k_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load_start) begin
          q_cnt_d = bus.q_words;
          k_cnt_d = bus.k_words;
          err_d   = bad_counts;
          if (!bad_counts) begin
            wptr_d  = '0;
            state_d = ST_LOAD_Q;
          end
        end
      end
      ST_LOAD_Q: begin
        if (bus.in_valid) begin
          q_we   = 1'b1;
          wptr_d = wptr_q + PTR_ONE;
          // in_last is never legal on a Q beat; the beat is still written.
          if (bus.in_last) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (q_final) begin
            wptr_d  = '0;
            state_d = ST_LOAD_K;
          end
        end
      end
      ST_LOAD_K: begin
        if (bus.in_valid) begin
          k_we   = 1'b1;
          wptr_d = wptr_q + PTR_ONE;
          // in_last must coincide exactly with the final K beat.
          if (bus.in_last != k_final) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (k_final) begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.core_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      q_cnt_q <= '0;
      k_cnt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      q_cnt_q <= q_cnt_d;
      k_cnt_q <= k_cnt_d;
      err_q   <= err_d;
    end
  end

  // Pure decodes of the registered state.
  assign bus.in_ready   = (state_q == ST_LOAD_Q) || (state_q == ST_LOAD_K);
  assign bus.core_start = (state_q == ST_LAUNCH);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.err        = err_q;

  spdot_spad_bank #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_q_bank (
    .clk   (clk),
    .we    (q_we),
    .waddr (wptr_q[AW-1:0]),
    .wdata (bus.in_data),
    .raddr (bus.q_raddr),
    .rdata (bus.q_rdata)
  );

  spdot_spad_bank #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_k_bank (
    .clk   (clk),
    .we    (k_we),
    .waddr (wptr_q[AW-1:0]),
    .wdata (bus.in_data),
    .raddr (bus.k_raddr),
    .rdata (bus.k_rdata)
  );

endmodule

// File: tb/tb_spdot_spad_loader.sv
// tb_spdot_spad_loader
//   Directed scenarios for spdot_spad_loader. Inputs change on the falling
//   edge and outputs are sampled on the falling edge (or shortly after it).
`timescale 1ns/1ps
module tb_spdot_spad_loader;
  import spdot_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  spdot_spad_loader_if #(.DW(32)) bus ();

  spdot_spad_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse load_start for one rising edge; ends on a falling edge.
  task automatic start_load(input logic [15:0] qn, input logic [15:0] kn);
    bus.load_start = 1'b1;
    bus.q_words    = qn;
    bus.k_words    = kn;
    @(negedge clk);
    bus.load_start = 1'b0;
  endtask

  // Stream qn Q words (qbase+i) then kn K words (kbase+i), in_last on the
  // final beat. With bubbles, in_valid follows the pattern 1,0,0,1.
  task automatic send_stream(input int qn, input int kn,
                             input logic [31:0] qbase, input logic [31:0] kbase,
                             input bit bubbles, output int early_pulses,
                             output bit pulse_after, output bit timeout);
    int  b = 0;
    int  c = 0;
    bit  v;
    early_pulses = 0;
    timeout      = 1'b0;
    while (b < qn + kn) begin
      if (c > 200) begin
        timeout = 1'b1;
        break;
      end
      v = bubbles ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = (b < qn) ? qbase + 32'(b) : kbase + 32'(b - qn);
      bus.in_last  = (b == qn + kn - 1);
      @(negedge clk);
      if (v) b++;
      c++;
      if (b < qn + kn && bus.core_start) early_pulses++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    pulse_after  = bus.core_start;
  endtask

  task automatic pulse_done();
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.core_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_core_start got=%b exp=0", bus.core_start); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", bus.err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int e; bit p; bit t;
    start_load(16'd4, 16'd4);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL basic_ready got=%b exp=1", bus.in_ready); end
    send_stream(4, 4, 32'h10, 32'h20, 1'b0, e, p, t);
    checks++; if (t !== 1'b0) begin failures++; $display("[TB] FAIL basic_timeout got=%b exp=0", t); end
    checks++; if (e !== 0) begin failures++; $display("[TB] FAIL basic_early_start got=%0d exp=0", e); end
    checks++; if (p !== 1'b1) begin failures++; $display("[TB] FAIL basic_start_pulse got=%b exp=1", p); end
    @(negedge clk);
    checks++; if (bus.core_start !== 1'b0) begin failures++; $display("[TB] FAIL basic_start_one_cycle got=%b exp=0", bus.core_start); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_wait_busy got=%b exp=1", bus.busy); end
    bus.q_raddr = 16'd2; bus.k_raddr = 16'd3; #1;
    checks++; if (bus.q_rdata !== 32'h12) begin failures++; $display("[TB] FAIL basic_q2 got=%h exp=00000012", bus.q_rdata); end
    checks++; if (bus.k_rdata !== 32'h23) begin failures++; $display("[TB] FAIL basic_k3 got=%h exp=00000023", bus.k_rdata); end
    bus.q_raddr = 16'd1024; bus.k_raddr = 16'hFFFF; #1;
    checks++; if (bus.q_rdata !== 32'h0) begin failures++; $display("[TB] FAIL oor_q got=%h exp=00000000", bus.q_rdata); end
    checks++; if (bus.k_rdata !== 32'h0) begin failures++; $display("[TB] FAIL oor_k got=%h exp=00000000", bus.k_rdata); end
    @(negedge clk);
    pulse_done();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_done_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_bubbles();
    int e; bit p; bit t;
    start_load(16'd4, 16'd4);
    send_stream(4, 4, 32'h50, 32'h60, 1'b1, e, p, t);
    checks++; if (t !== 1'b0) begin failures++; $display("[TB] FAIL bub_timeout got=%b exp=0", t); end
    checks++; if (e !== 0) begin failures++; $display("[TB] FAIL bub_early_start got=%0d exp=0", e); end
    checks++; if (p !== 1'b1) begin failures++; $display("[TB] FAIL bub_start_pulse got=%b exp=1", p); end
    for (int i = 0; i < 4; i++) begin
      bus.q_raddr = 16'(i); bus.k_raddr = 16'(i); #1;
      checks++; if (bus.q_rdata !== 32'h50 + 32'(i)) begin failures++; $display("[TB] FAIL bub_q%0d got=%h exp=%h", i, bus.q_rdata, 32'h50 + 32'(i)); end
      checks++; if (bus.k_rdata !== 32'h60 + 32'(i)) begin failures++; $display("[TB] FAIL bub_k%0d got=%h exp=%h", i, bus.k_rdata, 32'h60 + 32'(i)); end
    end
    @(negedge clk);
    pulse_done();
  endtask

  task automatic test_early_last();
    int starts = 0;
    start_load(16'd4, 16'd4);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h70 + 32'(i);
      bus.in_last  = (i == 2);
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    checks++; if (bus.err !== 1'b1) begin failures++; $display("[TB] FAIL early_err got=%b exp=1", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL early_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL early_ready got=%b exp=0", bus.in_ready); end
    for (int i = 0; i < 4; i++) begin
      if (bus.core_start) starts++;
      @(negedge clk);
    end
    checks++; if (starts !== 0) begin failures++; $display("[TB] FAIL early_no_start got=%0d exp=0", starts); end
  endtask

  task automatic test_missing_last();
    start_load(16'd1, 16'd1);
    bus.in_valid = 1'b1; bus.in_data = 32'h81; bus.in_last = 1'b0;
    @(negedge clk);
    bus.in_data = 32'h91;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.err !== 1'b1) begin failures++; $display("[TB] FAIL nolast_err got=%b exp=1", bus.err); end
    checks++; if (bus.core_start !== 1'b0) begin failures++; $display("[TB] FAIL nolast_start got=%b exp=0", bus.core_start); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL nolast_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_bad_counts();
    int e; bit p; bit t;
    start_load(16'd0, 16'd4);
    checks++; if (bus.err !== 1'b1) begin failures++; $display("[TB] FAIL q0_err got=%b exp=1", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL q0_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL q0_ready got=%b exp=0", bus.in_ready); end
    start_load(16'd1, 16'd1);
    checks++; if (bus.err !== 1'b0) begin failures++; $display("[TB] FAIL good_clears_err got=%b exp=0", bus.err); end
    send_stream(1, 1, 32'hA5, 32'hB5, 1'b0, e, p, t);
    checks++; if (p !== 1'b1) begin failures++; $display("[TB] FAIL one_word_start got=%b exp=1", p); end
    @(negedge clk);
    pulse_done();
    start_load(16'd4, 16'd1025);
    checks++; if (bus.err !== 1'b1) begin failures++; $display("[TB] FAIL k1025_err got=%b exp=1", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL k1025_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL k1025_ready got=%b exp=0", bus.in_ready); end
    start_load(16'd1024, 16'd1);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL q1024_accept got=%b exp=1", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("[TB] FAIL q1024_err got=%b exp=0", bus.err); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    int e; bit p; bit t;
    start_load(16'd2, 16'd2);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'hC0 + 32'(i); bus.in_last = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_ready got=%b exp=0", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    start_load(16'd2, 16'd2);
    send_stream(2, 2, 32'hA0, 32'hB0, 1'b0, e, p, t);
    checks++; if (p !== 1'b1 || e !== 0) begin failures++; $display("[TB] FAIL rst_reload_start got=%b/%0d exp=1/0", p, e); end
    bus.q_raddr = 16'd1; bus.k_raddr = 16'd0; #1;
    checks++; if (bus.q_rdata !== 32'hA1) begin failures++; $display("[TB] FAIL rst_reload_q1 got=%h exp=000000a1", bus.q_rdata); end
    checks++; if (bus.k_rdata !== 32'hB0) begin failures++; $display("[TB] FAIL rst_reload_k0 got=%h exp=000000b0", bus.k_rdata); end
    @(negedge clk);
    pulse_done();
  endtask

  task automatic test_launch_handshake();
    int e; bit p; bit t;
    start_load(16'd2, 16'd2);
    send_stream(2, 2, 32'h30, 32'h40, 1'b0, e, p, t);
    @(negedge clk);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL hs_wait_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL hs_wait_ready got=%b exp=0", bus.in_ready); end
    bus.core_done = 1'b1; bus.load_start = 1'b1; #1;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL hs_busy_before_edge got=%b exp=1", bus.busy); end
    @(negedge clk);
    bus.core_done = 1'b0; bus.load_start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL hs_done_idle got=%b exp=0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL hs_start_ignored got=%b exp=0", bus.busy); end
  endtask

  initial begin
    checks = 0; failures = 0;
    bus.load_start = 1'b0; bus.q_words = '0; bus.k_words = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.q_raddr = '0; bus.k_raddr = '0; bus.core_done = 1'b0;
    test_reset();
    test_basic();
    test_bubbles();
    test_early_last();
    test_missing_last();
    test_bad_counts();
    test_reset_mid_load();
    test_launch_handshake();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
